// File: rtl/minbd_prio_tagger.sv
// MinBD priority tagger: tags arriving flits with gold/silver flags and a tie-break
// bit, registered once so the arbiter tree sees aligned, tagged flits. Also holds
// the golden-packet epoch state and the per-router LFSR.
module minbd_prio_tagger #(
    parameter int unsigned NUM_PORT    = 4,
    parameter int unsigned NUM_NODE    = 16,
    parameter int unsigned WIDTH_SRC   = 4,
    parameter int unsigned WIDTH_PKTID = 4,
    parameter int unsigned GOLD_EPOCH  = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_PORT-1:0]             in_vld,
    input  logic [NUM_PORT*WIDTH_SRC-1:0]   in_src,
    input  logic [NUM_PORT*WIDTH_PKTID-1:0] in_pktid,
    output logic [NUM_PORT-1:0]             out_vld,
    output logic [NUM_PORT-1:0]             out_gold,
    output logic [NUM_PORT-1:0]             out_silver,
    output logic                            rand_num,
    output logic [WIDTH_SRC-1:0]            gold_src,
    output logic [WIDTH_PKTID-1:0]          gold_pktid
);

    localparam int unsigned PortW  = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam int unsigned EpochW = $clog2(GOLD_EPOCH);
    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    logic [EpochW-1:0]      r_epoch_cnt;
    logic [WIDTH_SRC-1:0]   r_gold_src;
    logic [WIDTH_PKTID-1:0] r_gold_pktid;
    logic [15:0]            r_lfsr;
    logic [NUM_PORT-1:0]    r_out_vld;
    logic [NUM_PORT-1:0]    r_out_gold;
    logic [NUM_PORT-1:0]    r_out_silver;
    logic                   r_rand_num;

    logic [NUM_PORT-1:0]    w_gold;
    logic [NUM_PORT-1:0]    w_cand;
    logic [NUM_PORT-1:0]    w_silver;
    logic                   w_found;
    logic                   w_fb;
    logic                   w_epoch_wrap;
    int unsigned            w_start;

    assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_epoch_wrap = (r_epoch_cnt == EpochW'(GOLD_EPOCH - 1));
    assign w_cand       = in_vld & ~w_gold;

    // Gold match against the golden id as registered before this edge's update.
    always_comb begin
        w_gold = '0;
        for (int unsigned p = 0; p < NUM_PORT; p++) begin
            w_gold[p] = in_vld[p]
                && (in_src[p*WIDTH_SRC +: WIDTH_SRC] == r_gold_src)
                && (in_pktid[p*WIDTH_PKTID +: WIDTH_PKTID] == r_gold_pktid);
        end
    end

    // Silver: first non-gold valid port at or after the LFSR-chosen start, cyclically.
    always_comb begin
        w_silver = '0;
        w_found  = 1'b0;
        w_start  = 32'(r_lfsr[PortW:1]) % NUM_PORT;
        for (int unsigned k = 0; k < NUM_PORT; k++) begin
            for (int unsigned p = 0; p < NUM_PORT; p++) begin
                if (!w_found && w_cand[p] && (p == (w_start + k) % NUM_PORT)) begin
                    w_silver[p] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

    // Golden epoch counter and golden id advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epoch_cnt  <= '0;
            r_gold_src   <= '0;
            r_gold_pktid <= '0;
        end else if (en) begin
            if (w_epoch_wrap) begin
                r_epoch_cnt  <= '0;
                r_gold_pktid <= r_gold_pktid + 1'b1;
                if (r_gold_pktid == '1) begin
                    if (r_gold_src == WIDTH_SRC'(NUM_NODE - 1)) begin
                        r_gold_src <= '0;
                    end else begin
                        r_gold_src <= r_gold_src + 1'b1;
                    end
                end
            end else begin
                r_epoch_cnt <= r_epoch_cnt + 1'b1;
            end
        end
    end

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, stepped only on enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SeedEff;
        end else if (en) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    // Output pipeline register; always runs regardless of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld    <= '0;
            r_out_gold   <= '0;
            r_out_silver <= '0;
            r_rand_num   <= 1'b0;
        end else begin
            r_out_vld    <= in_vld;
            r_out_gold   <= w_gold;
            r_out_silver <= w_silver;
            r_rand_num   <= r_lfsr[0];
        end
    end

    assign out_vld    = r_out_vld;
    assign out_gold   = r_out_gold;
    assign out_silver = r_out_silver;
    assign rand_num   = r_rand_num;
    assign gold_src   = r_gold_src;
    assign gold_pktid = r_gold_pktid;

endmodule

// File: tb/tb_minbd_prio_tagger.sv
// Self-checking bench for minbd_prio_tagger: cycle model compare plus directed literals.
module tb_minbd_prio_tagger;

    localparam int unsigned NP   = 4;
    localparam int unsigned NN   = 4;
    localparam int unsigned WS   = 4;
    localparam int unsigned WP   = 2;
    localparam int unsigned GE   = 8;
    localparam logic [15:0] SEED = 16'h0000;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [NP-1:0] in_vld;
    logic [NP*WS-1:0] in_src;
    logic [NP*WP-1:0] in_pktid;
    logic [NP-1:0] out_vld;
    logic [NP-1:0] out_gold;
    logic [NP-1:0] out_silver;
    logic          rand_num;
    logic [WS-1:0] gold_src;
    logic [WP-1:0] gold_pktid;

    minbd_prio_tagger #(
        .NUM_PORT   (NP),
        .NUM_NODE   (NN),
        .WIDTH_SRC  (WS),
        .WIDTH_PKTID(WP),
        .GOLD_EPOCH (GE),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_vld    (in_vld),
        .in_src    (in_src),
        .in_pktid  (in_pktid),
        .out_vld   (out_vld),
        .out_gold  (out_gold),
        .out_silver(out_silver),
        .rand_num  (rand_num),
        .gold_src  (gold_src),
        .gold_pktid(gold_pktid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden id as a pure function of the number of enabled cycles since reset.
    function automatic int gsrc_of(input int n);
        return (n / (GE * (1 << WP))) % NN;
    endfunction

    function automatic int gpkt_of(input int n);
        return (n / GE) % (1 << WP);
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [NP-1:0] gold_of(input logic [NP-1:0] v, input logic [NP*WS-1:0] s,
                                              input logic [NP*WP-1:0] p, input int n);
        logic [NP-1:0] g;
        g = '0;
        for (int i = 0; i < NP; i++) begin
            if (v[i] && (int'(s[i*WS +: WS]) == gsrc_of(n)) && (int'(p[i*WP +: WP]) == gpkt_of(n)))
                g[i] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [NP-1:0] silver_of(input logic [NP-1:0] v, input logic [NP-1:0] g,
                                                input logic [15:0] l);
        logic [NP-1:0] c;
        int st;
        int q;
        c  = v & ~g;
        st = int'((l >> 1) & 16'h3) % NP;
        for (int k = 0; k < NP; k++) begin
            q = (st + k) % NP;
            if (c[q[1:0]]) return 4'(1 << q);
        end
        return '0;
    endfunction

    int            m_n;
    logic [15:0]   m_lfsr;
    logic [NP-1:0] e_vld;
    logic [NP-1:0] e_gold;
    logic [NP-1:0] e_silver;
    logic          e_rand;

    // Reference model state and expected registered outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n      <= 0;
            m_lfsr   <= SEED_EFF;
            e_vld    <= '0;
            e_gold   <= '0;
            e_silver <= '0;
            e_rand   <= 1'b0;
        end else begin
            e_vld    <= in_vld;
            e_gold   <= gold_of(in_vld, in_src, in_pktid, m_n);
            e_silver <= silver_of(in_vld, gold_of(in_vld, in_src, in_pktid, m_n), m_lfsr);
            e_rand   <= m_lfsr[0];
            if (en) begin
                m_n    <= m_n + 1;
                m_lfsr <= lfsr_next(m_lfsr);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_vld",    32'(out_vld),    32'(e_vld));
        chk("m_gold",   32'(out_gold),   32'(e_gold));
        chk("m_silver", 32'(out_silver), 32'(e_silver));
        chk("m_rand",   32'(rand_num),   32'(e_rand));
        chk("m_gsrc",   32'(gold_src),   32'(gsrc_of(m_n)));
        chk("m_gpkt",   32'(gold_pktid), 32'(gpkt_of(m_n)));
    end

    task automatic cyc(input logic e, input logic [NP-1:0] v, input logic [NP*WS-1:0] s,
                       input logic [NP*WP-1:0] p);
        en       = e;
        in_vld   = v;
        in_src   = s;
        in_pktid = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [NP*WS-1:0] rs;
        logic [NP*WP-1:0] rp;
        rst_n    = 1'b0;
        en       = 1'b0;
        in_vld   = '0;
        in_src   = '0;
        in_pktid = '0;
        #1;
        chk("rst_out", {28'd0, out_vld | out_gold | out_silver}, 32'd0);
        chk("rst_rand", 32'(rand_num), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rel_gsrc", 32'(gold_src), 32'd0);
        chk("rel_gpkt", 32'(gold_pktid), 32'd0);
        chk("model_lfsr_seed", 32'(m_lfsr), 32'hACE1);
        chk("model_lfsr_step", 32'(lfsr_next(m_lfsr)), 32'h59C3);

        // Ports 1 and 3 gold; lfsr=ACE1 gives start 0 -> silver on port 0.
        cyc(1'b0, 4'b1111, 16'h0101, 8'h00);
        chk("gold_1010", 32'(out_gold), 32'b1010);
        chk("silver_0001", 32'(out_silver), 32'b0001);
        chk("rand_seed0", 32'(rand_num), 32'd1);

        // Two steps: ACE1 -> 59C3 -> B387, start bits [2:1]=11.
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        chk("idle_gold", 32'(out_gold), 32'd0);
        chk("idle_silver", 32'(out_silver), 32'd0);
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        chk("model_lfsr_b387", 32'(m_lfsr), 32'hB387);

        // Wrap-around scan from port 3 lands on port 0.
        cyc(1'b0, 4'b0011, 16'h1111, 8'h00);
        chk("silver_wrap", 32'(out_silver), 32'b0001);
        chk("silver_wrap_gold", 32'(out_gold), 32'd0);

        // Only flit is gold: no silver.
        cyc(1'b0, 4'b0100, 16'h1011, 8'h00);
        chk("solo_gold", 32'(out_gold), 32'b0100);
        chk("solo_silver", 32'(out_silver), 32'd0);

        // Run the golden id through a full source sweep.
        while (m_n < 128) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rs[i*WS +: WS] = 4'(gsrc_of(m_n));
                    rp[i*WP +: WP] = 2'(gpkt_of(m_n));
                end else begin
                    rs[i*WS +: WS] = 4'($urandom_range(0, 3));
                    rp[i*WP +: WP] = 2'($urandom_range(0, 3));
                end
            end
            cyc(1'b1, 4'($urandom_range(0, 15)), rs, rp);
            if (m_n == 8) chk("ep8_gpkt", 32'(gold_pktid), 32'd1);
            if (m_n == 32) chk("ep32_gsrc", 32'(gold_src), 32'd1);
            if (m_n == 127) begin
                chk("ep127_gsrc", 32'(gold_src), 32'd3);
                chk("ep127_gpkt", 32'(gold_pktid), 32'd3);
            end
        end
        chk("ep128_gsrc", 32'(gold_src), 32'd0);
        chk("ep128_gpkt", 32'(gold_pktid), 32'd0);

        // Bring epoch_cnt to 5, then hold for 20 cycles while still tagging.
        while (m_n < 133) cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 4'b1111, 16'h0000, 8'h00);
            if (i == 0) chk("hold_gold", 32'(out_gold), 32'b1111);
        end
        chk("hold_gpkt", 32'(gold_pktid), 32'd0);
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        chk("resume2_gpkt", 32'(gold_pktid), 32'd0);
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        chk("resume3_gpkt", 32'(gold_pktid), 32'd1);

        // Golden id is {0,1}: put a gold flit on port 1, then reset mid-cycle.
        cyc(1'b0, 4'b0010, 16'h0000, 8'h04);
        chk("pre_rst_gold", 32'(out_gold), 32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gold", 32'(out_gold), 32'd0);
        chk("async_rst_vld", 32'(out_vld), 32'd0);
        chk("async_rst_gpkt", 32'(gold_pktid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // One step from ACE1 gives 59C3, start 1 -> silver on port 1.
        cyc(1'b1, 4'b0000, 16'h0000, 8'h00);
        cyc(1'b0, 4'b1111, 16'h1111, 8'h00);
        chk("reseed_silver", 32'(out_silver), 32'b0010);
        chk("reseed_vld", 32'(out_vld), 32'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
